wokwi_395055341723330561_tile: RTL and testbench



---
 rtl/wokwi_tile_pkg.sv | 21 ++
 rtl/seg7_decoder.sv | 13 +
 rtl/wokwi_395055341723330561_tile.sv | 105 ++++++++++
 tb/tb_wokwi_395055341723330561_tile.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wokwi_tile_pkg.sv
// Shared constants for the 7-segment up/down counter tile: segment table,
// count limits and ui_in field positions.
package wokwi_tile_pkg;

    localparam logic [3:0] DEC_MAX = 4'd9;
    localparam logic [3:0] HEX_MAX = 4'd15;

    localparam int unsigned UI_EN       = 0;
    localparam int unsigned UI_DIR      = 1;
    localparam int unsigned UI_LOAD     = 2;
    localparam int unsigned UI_MODE     = 3;
    localparam int unsigned UI_VAL_LSB  = 4;
    localparam int unsigned UI_VAL_MSB  = 7;

    // Active-high segments, bit0 = a .. bit6 = g; entry 15 listed first.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-digit to 7-segment decode (active-high, bit0 = a).
module seg7_decoder
    import wokwi_tile_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE[value_i];
    end

endmodule

// File: rtl/wokwi_395055341723330561_tile.sv
// Decimal/hex up/down counter with parallel load, terminal-count pulse and
// 7-segment output. Define PRESCALER_EN to gate counting with a free-running prescaler.
module wokwi_395055341723330561_tile
    import wokwi_tile_pkg::*;
#(
    parameter int unsigned PRESCALE_BITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    logic       en;
    logic       up;
    logic       load;
    logic       hex_mode;
    logic [3:0] load_val;
    logic [3:0] max_val;
    logic       step;

    logic [3:0] cnt_q, cnt_d;
    logic       tc_q, tc_d;
    logic [6:0] seg;

    assign en       = ui_in[UI_EN];
    assign up       = ui_in[UI_DIR];
    assign load     = ui_in[UI_LOAD];
    assign hex_mode = ui_in[UI_MODE];
    assign load_val = ui_in[UI_VAL_MSB:UI_VAL_LSB];
    assign max_val  = hex_mode ? HEX_MAX : DEC_MAX;

`ifdef PRESCALER_EN
    logic [PRESCALE_BITS-1:0] presc_q, presc_d;

    assign step = en && (&presc_q);

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (load) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE_BITS;
    assign step            = en;
`endif

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            // Out-of-range decimal loads clamp to zero.
            cnt_d = (!hex_mode && (load_val > DEC_MAX)) ? 4'd0 : load_val;
        end else if (step) begin
            if (up) begin
                if (cnt_q == max_val) begin
                    cnt_d = 4'd0;
                    tc_d  = 1'b1;
                end else if (cnt_q > max_val) begin
                    cnt_d = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                if (cnt_q == 4'd0) begin
                    cnt_d = max_val;
                    tc_d  = 1'b1;
                end else if (cnt_q > max_val) begin
                    cnt_d = DEC_MAX;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    seg7_decoder u_seg7_decoder (
        .value_i (cnt_q),
        .seg_o   (seg)
    );

    assign uo_out = {tc_q, seg};

endmodule

// File: tb/tb_wokwi_395055341723330561_tile.sv
// Self-checking bench for the counter tile against a behavioural reference model.
module tb_wokwi_395055341723330561_tile;

    localparam int PB = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int checks;
    int passes;

    int m_cnt;
    bit m_tc;
    int m_pre;

    logic [6:0] seg_ref [16];

    wokwi_395055341723330561_tile #(
        .PRESCALE_BITS (PB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] expected();
        return {m_tc, seg_ref[m_cnt]};
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_tc  = 1'b0;
        m_pre = 0;
    endtask

    task automatic model_edge(input logic [7:0] u);
        int  mx;
        int  v;
        bit  stp;
        mx  = u[3] ? 15 : 9;
        v   = int'(u[7:4]);
        stp = u[0];
`ifdef PRESCALER_EN
        stp = u[0] && (m_pre == (1 << PB) - 1);
`endif
        m_tc = 1'b0;
        if (u[2]) begin
            m_cnt = (!u[3] && v > 9) ? 0 : v;
            m_pre = 0;
        end else begin
            m_pre = (m_pre + 1) % (1 << PB);
            if (stp) begin
                if (u[1]) begin
                    if (m_cnt == mx) begin
                        m_cnt = 0;
                        m_tc  = 1'b1;
                    end else if (m_cnt > mx) begin
                        m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        m_cnt = mx;
                        m_tc  = 1'b1;
                    end else if (m_cnt > mx) begin
                        m_cnt = 9;
                    end else begin
                        m_cnt = m_cnt - 1;
                    end
                end
            end
        end
    endtask

    // Advance one clock, update model with inputs seen at the edge, settle 1ns.
    task automatic tick();
        @(posedge clk);
        model_edge(ui_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ui_in = 8'($urandom);
        model_reset();
        #3;
        checks++;
        if (uo_out !== 8'h3F) $display("FAIL reset_asserted: got %h want 3f", uo_out);
        else passes++;
        @(negedge clk);
        ui_in = 8'h00;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (uo_out !== 8'h3F) $display("FAIL reset_hold[%0d]: got %h want 3f", i, uo_out);
            else passes++;
        end
    endtask

    task automatic test_dec_up();
        ui_in = 8'b0000_0011;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (uo_out !== expected())
                $display("FAIL dec_up[%0d]: got %h want %h", i, uo_out, expected());
            else passes++;
        end
        ui_in = 8'h00;
        tick();
        checks++;
        if (uo_out !== expected())
            $display("FAIL dec_up_tc_drop: got %h want %h", uo_out, expected());
        else passes++;
    endtask

    task automatic test_hex_down();
        ui_in = 8'b0000_1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (uo_out !== expected())
                $display("FAIL hex_down[%0d]: got %h want %h", i, uo_out, expected());
            else passes++;
        end
    endtask

    task automatic test_load();
        ui_in = 8'b1100_1111;
        tick();
        checks++;
        if (uo_out !== expected())
            $display("FAIL load_hex_c: got %h want %h", uo_out, expected());
        else passes++;
        ui_in = 8'b1100_0111;
        tick();
        checks++;
        if (uo_out !== expected())
            $display("FAIL load_dec_clamp: got %h want %h", uo_out, expected());
        else passes++;
    endtask

    task automatic test_mode_switch();
        ui_in = 8'b1100_1100;
        tick();
        ui_in = 8'b0000_0011;
        tick();
        checks++;
        if (uo_out !== expected())
            $display("FAIL mode_switch_up: got %h want %h", uo_out, expected());
        else passes++;
        // Same out-of-range state, counting down lands on 9.
        ui_in = 8'b1100_1100;
        tick();
        ui_in = 8'b0000_0001;
        tick();
        checks++;
        if (uo_out !== expected())
            $display("FAIL mode_switch_down: got %h want %h", uo_out, expected());
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] u;
        for (int i = 0; i < 400; i++) begin
            u = 8'($urandom);
            if ($urandom_range(0, 7) != 0) u[2] = 1'b0;
            if ($urandom_range(0, 3) != 0) u[0] = 1'b1;
            ui_in = u;
            tick();
            checks++;
            if (uo_out !== expected())
                $display("FAIL random[%0d] ui=%h: got %h want %h", i, u, uo_out, expected());
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        ui_in = 8'b0111_0100;
        tick();
        ui_in = 8'b0000_0000;
        checks++;
        if (uo_out !== expected())
            $display("FAIL async_preload: got %h want %h", uo_out, expected());
        else passes++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (uo_out !== 8'h3F) $display("FAIL async_reset: got %h want 3f", uo_out);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        ui_in = 8'b0000_0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (uo_out !== expected())
                $display("FAIL post_reset[%0d]: got %h want %h", i, uo_out, expected());
            else passes++;
        end
    endtask

    initial begin
        seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        test_reset();
        test_dec_up();
        test_hex_down();
        test_load();
        test_mode_switch();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
